// File: rtl/spi_target.sv
// spi_target: SPI peripheral-side controller with an Avalon-MM register map.
// Define SPI_TARGET_IRQ_EN to build the registered interrupt output.
module spi_target #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] { IDLE, SHIFT, COMMIT } state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_q, scs_q, smosi_q;
  logic sclk_p_q, scs_p_q;
  logic sclk_s, cs_s, mosi_s;
  logic cs_fall, clk_rise, clk_fall, lead, trail, smp, shf;

  logic [4:0] ctrl_ws_q, act_ws_q, ws;
  logic       en_q, cpha_q, cpol_q, act_cpha_q, act_cpol_q, cpha, cpol;
  logic       irq_rx_en, irq_err_en;

  logic [31:0] tx_mem [FIFO_DEPTH];
  logic [31:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_push_ok, tx_pop, rx_push, rx_push_ok, rx_pop;

  logic rd_en, wr_en, rd_prev_q, w1c, ctrl_wr;
  logic txfo_q, rxfo_q, txur_q, cs_act_q, txur_set;

  logic [31:0] tx_word_q, tx_word_d, rx_word_q, rx_word_d, ld_word;
  logic [4:0]  idx_q, idx_d;
  logic        miso_q, miso_d, smpd_q, smpd_d, load;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s   = scs_q[SYNC_STAGES-1];
  assign mosi_s = smosi_q[SYNC_STAGES-1];

  // synchronize the SPI pins; one history flop per clock/select for edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q   <= '0;
      scs_q    <= '1;
      smosi_q  <= '0;
      sclk_p_q <= 1'b0;
      scs_p_q  <= 1'b1;
    end else begin
      sclk_q[0]  <= spi_clk;
      scs_q[0]   <= spi_cs_n;
      smosi_q[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_q[i]  <= sclk_q[i-1];
        scs_q[i]   <= scs_q[i-1];
        smosi_q[i] <= smosi_q[i-1];
      end
      sclk_p_q <= sclk_s;
      scs_p_q  <= cs_s;
    end
  end

  assign cs_fall  = ~cs_s & scs_p_q;
  assign clk_rise = sclk_s & ~sclk_p_q;
  assign clk_fall = ~sclk_s & sclk_p_q;

  // mode/size follow CONTROL while idle and freeze during a frame
  assign ws    = (state_q == IDLE) ? ctrl_ws_q : act_ws_q;
  assign cpha  = (state_q == IDLE) ? cpha_q : act_cpha_q;
  assign cpol  = (state_q == IDLE) ? cpol_q : act_cpol_q;
  assign lead  = cpol ? clk_fall : clk_rise;
  assign trail = cpol ? clk_rise : clk_fall;
  assign smp   = cpha ? trail : lead;
  assign shf   = cpha ? lead : trail;

  assign rd_en   = read & chipselect;
  assign wr_en   = write & chipselect;
  assign w1c     = wr_en && address == 2'd1;
  assign ctrl_wr = wr_en && address == 2'd2;

  assign tx_empty = tx_cnt_q == '0;
  assign tx_full  = tx_cnt_q == FULL;
  assign rx_empty = rx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == FULL;

  assign tx_push    = wr_en && address == 2'd0;
  assign tx_push_ok = tx_push && (!tx_full || tx_pop);
  assign rx_pop     = rd_en && address == 2'd0 && !rd_prev_q && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);
  assign ld_word    = tx_empty ? '0 : tx_mem[tx_rd_q];

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wr_q] <= writedata;
    if (rx_push_ok) rx_mem[rx_wr_q] <= rx_word_q;
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push_ok) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)     tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push_ok) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)     rx_rd_q <= rx_rd_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + CW'(tx_push_ok) - CW'(tx_pop);
      rx_cnt_q <= rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop);
    end
  end

  // sticky status flags (set wins over W1C), CS tracking, read-edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txfo_q    <= 1'b0;
      rxfo_q    <= 1'b0;
      txur_q    <= 1'b0;
      cs_act_q  <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      txfo_q    <= (tx_push & ~tx_push_ok) | (txfo_q & ~(w1c & writedata[3]));
      rxfo_q    <= (rx_push & ~rx_push_ok) | (rxfo_q & ~(w1c & writedata[0]));
      txur_q    <= txur_set | (txur_q & ~(w1c & writedata[6]));
      cs_act_q  <= ~cs_s;
      rd_prev_q <= rd_en && address == 2'd0;
    end
  end

  // CONTROL register and the copy that is live during a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_ws_q  <= '0;
      en_q       <= 1'b0;
      cpha_q     <= 1'b0;
      cpol_q     <= 1'b0;
      act_ws_q   <= '0;
      act_cpha_q <= 1'b0;
      act_cpol_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_ws_q <= writedata[4:0];
        en_q      <= writedata[15];
        cpha_q    <= writedata[16];
        cpol_q    <= writedata[17];
      end
      if (state_q == IDLE) begin
        act_ws_q   <= ctrl_ws_q;
        act_cpha_q <= cpha_q;
        act_cpol_q <= cpol_q;
      end
    end
  end

  // transfer FSM state register and shift datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_word_q <= '0;
      rx_word_q <= '0;
      idx_q     <= '0;
      miso_q    <= 1'b0;
      smpd_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_word_q <= tx_word_d;
      rx_word_q <= rx_word_d;
      idx_q     <= idx_d;
      miso_q    <= miso_d;
      smpd_q    <= smpd_d;
    end
  end

  // next state; smpd gates CPHA=0 shifts so the edge after a word's
  // final sample cannot shift the freshly reloaded word
  always_comb begin
    state_d   = state_q;
    tx_word_d = tx_word_q;
    rx_word_d = rx_word_q;
    idx_d     = idx_q;
    miso_d    = miso_q;
    smpd_d    = smpd_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    txur_set  = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall && en_q) load = 1'b1;
      end
      SHIFT: begin
        if (cs_s || !en_q) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else if (smp) begin
          rx_word_d = {rx_word_q[30:0], mosi_s};
          smpd_d    = 1'b1;
          if (cpha) idx_d = idx_q - 5'd1;
          if (idx_q == 5'd0) state_d = COMMIT;
        end else if (shf) begin
          if (cpha) begin
            miso_d = tx_word_q[idx_q];
          end else if (smpd_q) begin
            idx_d  = idx_q - 5'd1;
            miso_d = tx_word_q[idx_q - 5'd1];
            smpd_d = 1'b0;
          end
        end
      end
      COMMIT: begin
        rx_push = 1'b1;
        if (!cs_s && en_q) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      tx_pop    = !tx_empty;
      txur_set  = tx_empty;
      tx_word_d = ld_word;
      idx_d     = ws;
      miso_d    = ld_word[ws];
      rx_word_d = '0;
      smpd_d    = 1'b0;
      state_d   = SHIFT;
    end
  end

`ifdef SPI_TARGET_IRQ_EN
  logic irq_rx_en_q, irq_err_en_q, irq_q;
  assign irq_rx_en  = irq_rx_en_q;
  assign irq_err_en = irq_err_en_q;
  assign irq        = irq_q;

  // interrupt enables and the registered interrupt request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_rx_en_q  <= 1'b0;
      irq_err_en_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_rx_en_q  <= writedata[18];
        irq_err_en_q <= writedata[19];
      end
      irq_q <= (irq_rx_en_q & ~rx_empty) |
               (irq_err_en_q & (rxfo_q | txfo_q | txur_q));
    end
  end
`else
  assign irq_rx_en  = 1'b0;
  assign irq_err_en = 1'b0;
  assign irq        = 1'b0;
`endif

  assign spi_miso    = miso_q;
  assign spi_miso_oe = state_q != IDLE;

  // register read mux
  always_comb begin
    readdata = '0;
    if (rd_en) begin
      unique case (address)
        2'd0: readdata = rx_empty ? '0 : rx_mem[rx_rd_q];
        2'd1: readdata = {24'b0, cs_act_q, txur_q, tx_empty, tx_full,
                          txfo_q, rx_empty, rx_full, rxfo_q};
        2'd2: readdata = {12'b0, irq_err_en, irq_rx_en, cpol_q, cpha_q,
                          en_q, 10'b0, ctrl_ws_q};
        2'd3: readdata = {11'b0, 5'(rx_cnt_q), 11'b0, 5'(tx_cnt_q)};
        default: readdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: drives spi_target as an SPI controller and bus master,
// predicting MISO, RX contents and status from a queue-based model.
module tb_spi_target;
  localparam int H = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0, write = 1'b0, chipselect = 1'b0;
  logic [1:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, irq;

  spi_target dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .chipselect(chipselect), .address(address), .writedata(writedata),
    .readdata(readdata), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .irq(irq)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nb;
  bit cpol, cpha;
  logic [31:0] mosi_w [32];
  logic [31:0] miso_w [32];
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit m_txur, m_txfo, m_rxfo;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(logic [1:0] a, logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  function automatic logic [31:0] mask(int n);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  function automatic logic [31:0] m_load();
    if (txq.size() > 0) return txq.pop_front();
    m_txur = 1'b1;
    return '0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[6] = m_txur;
    s[5] = txq.size() == 0;
    s[4] = txq.size() == 16;
    s[3] = m_txfo;
    s[2] = rxq.size() == 0;
    s[1] = rxq.size() == 16;
    s[0] = m_rxfo;
    return s;
  endfunction

  function automatic logic [31:0] ctrl_word(int m, int n, bit irx);
    logic [31:0] c = '0;
    c[4:0] = 5'(n - 1);
    c[15]  = 1'b1;
    c[16]  = m[0];
    c[17]  = m[1];
    c[18]  = irx;
    return c;
  endfunction

  task automatic set_mode(int m, int n);
    cpol = m[1];
    cpha = m[0];
    nb   = n;
    bus_wr(2, ctrl_word(m, n, 1'b0));
    spi_clk = cpol;
    tick(4);
  endtask

  task automatic tx_write(logic [31:0] d);
    if (txq.size() < 16) txq.push_back(d);
    else m_txfo = 1'b1;
    bus_wr(0, d);
  endtask

  // cut > 0 sends only that many bits of word 0 and leaves CS low
  task automatic frame(int nw, int cut);
    logic [31:0] g;
    int stop;
    stop = (cut > 0) ? nb - cut : 0;
    spi_cs_n = 1'b0;
    tick(2);
    for (int w = 0; w < nw; w++) begin
      g = '0;
      for (int i = nb - 1; i >= stop; i--) begin
        if (!cpha) begin
          spi_mosi = mosi_w[w][i];
          tick(H);
          g[i] = spi_miso;
          spi_clk = ~cpol;
          tick(H);
          spi_clk = cpol;
        end else begin
          tick(H);
          spi_clk = ~cpol;
          spi_mosi = mosi_w[w][i];
          tick(H);
          g[i] = spi_miso;
          spi_clk = cpol;
        end
      end
      miso_w[w] = g;
    end
    if (cut == 0) begin
      tick(H);
      spi_cs_n = 1'b1;
      tick(8);
    end
  endtask

  // CS stays low past each word, so one more TX load happens and is lost
  task automatic m_frame_check(int nw, string tag);
    logic [31:0] e;
    for (int w = 0; w < nw; w++) begin
      e = m_load() & mask(nb);
      check(tag, miso_w[w], e);
      if (rxq.size() < 16) rxq.push_back(mosi_w[w] & mask(nb));
      else m_rxfo = 1'b1;
    end
    void'(m_load());
  endtask

  task automatic drain(string tag);
    logic [31:0] d;
    bus_rd(3, d);
    check({tag, "-level"}, d, (32'(rxq.size()) << 16) | 32'(txq.size()));
    while (rxq.size() > 0) begin
      bus_rd(0, d);
      check({tag, "-data"}, d, rxq.pop_front());
    end
    bus_rd(1, d);
    check({tag, "-status"}, d, m_status());
  endtask

  initial begin
    logic [31:0] d;
    int m, n, nw, np;

    #1;
    check("rst-miso", 32'(spi_miso), 0);
    check("rst-oe", 32'(spi_miso_oe), 0);
    check("rst-irq", 32'(irq), 0);
    check("rst-readdata", readdata, 0);
    tick(3);
    reset = 1'b0;
    bus_rd(1, d); check("rst-status", d, 32'h24);
    bus_rd(2, d); check("rst-control", d, 0);
    bus_rd(3, d); check("rst-level", d, 0);

    set_mode(0, 8);
    tx_write(32'hA5);
    mosi_w[0] = 32'h3C;
    frame(1, 0);
    m_frame_check(1, "m0-miso");
    drain("m0");
    bus_rd(0, d); check("m0-empty-read", d, 0);

    set_mode(3, 16);
    tx_write(32'h1234);
    tx_write(32'hBEEF);
    mosi_w[0] = $urandom();
    mosi_w[1] = $urandom();
    frame(2, 0);
    m_frame_check(2, "m3-miso");
    drain("m3");

    set_mode(0, 8);
    bus_wr(1, 32'h49);
    m_txur = 1'b0;
    mosi_w[0] = 32'h55;
    frame(1, 0);
    m_frame_check(1, "ur-miso");
    drain("ur");
    bus_wr(1, 32'h40);
    m_txur = 1'b0;
    bus_rd(1, d); check("ur-w1c", d, m_status());

    set_mode(1, 8);
    for (int i = 0; i < 17; i++) tx_write($urandom());
    bus_rd(1, d); check("txfo-status", d, m_status());
    for (int i = 0; i < 16; i++) mosi_w[i] = $urandom();
    frame(16, 0);
    m_frame_check(16, "full-miso");
    bus_rd(1, d); check("rxff-status", d, m_status());
    mosi_w[0] = $urandom();
    frame(1, 0);
    m_frame_check(1, "ovf-miso");
    drain("ovf");
    bus_wr(1, 32'h49);
    m_txur = 1'b0; m_txfo = 1'b0; m_rxfo = 1'b0;
    bus_rd(1, d); check("ovf-w1c", d, m_status());

    set_mode(0, 8);
    tx_write($urandom());
    tx_write($urandom());
    mosi_w[0] = $urandom();
    frame(1, 5);
    tick(H);
    spi_cs_n = 1'b1;
    tick(8);
    void'(m_load());
    bus_rd(3, d); check("abort-level", d, 32'(txq.size()));
    mosi_w[0] = 32'h81;
    frame(1, 0);
    m_frame_check(1, "abort-next-miso");
    drain("abort");

    set_mode(3, 12);
    for (int i = 0; i < 3; i++) tx_write($urandom());
    mosi_w[0] = $urandom();
    frame(1, 3);
    bus_rd(1, d); check("cs-active", d & 32'h80, 32'h80);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst-miso", 32'(spi_miso), 0);
    check("arst-oe", 32'(spi_miso_oe), 0);
    check("arst-irq", 32'(irq), 0);
    chipselect = 1'b1; read = 1'b1; address = 2'd3;
    #1 check("arst-level", readdata, 0);
    address = 2'd2;
    #1 check("arst-control", readdata, 0);
    chipselect = 1'b0; read = 1'b0;
    txq.delete(); rxq.delete();
    m_txur = 1'b0; m_txfo = 1'b0; m_rxfo = 1'b0;
    tick(2);
    reset = 1'b0;
    spi_cs_n = 1'b1;
    tick(8);
    set_mode(3, 12);
    tx_write($urandom());
    mosi_w[0] = $urandom();
    frame(1, 0);
    m_frame_check(1, "post-rst-miso");
    drain("post-rst");

    for (int it = 0; it < 8; it++) begin
      m  = $urandom_range(0, 3);
      n  = $urandom_range(1, 32);
      nw = $urandom_range(1, 3);
      np = $urandom_range(0, nw + 1);
      set_mode(m, n);
      bus_wr(1, 32'h49);
      m_txur = 1'b0; m_txfo = 1'b0; m_rxfo = 1'b0;
      for (int i = 0; i < np; i++) tx_write($urandom());
      for (int i = 0; i < nw; i++) mosi_w[i] = $urandom();
      frame(nw, 0);
      m_frame_check(nw, $sformatf("rnd%0d-miso", it));
      drain($sformatf("rnd%0d", it));
    end

    bus_wr(2, ctrl_word(0, 8, 1'b1));
    cpol = 1'b0; cpha = 1'b0; nb = 8;
    spi_clk = 1'b0;
    tick(2);
    bus_rd(2, d);
`ifdef SPI_TARGET_IRQ_EN
    check("irq-ctrl", d, ctrl_word(0, 8, 1'b1));
`else
    check("irq-ctrl", d, ctrl_word(0, 8, 1'b0));
`endif
    mosi_w[0] = $urandom();
    frame(1, 0);
    m_frame_check(1, "irq-miso");
    tick(2);
`ifdef SPI_TARGET_IRQ_EN
    check("irq-rx", 32'(irq), 1);
`else
    check("irq-rx", 32'(irq), 0);
`endif
    drain("irq");
    tick(2);
    check("irq-clear", 32'(irq), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
